// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache/dcache line requests onto one burst memory port, assembling and serializing lines.
// Optional `ARB_RR_EN: round-robin between icache and dcache instead of fixed dcache priority.
module cache_mem_arbiter #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_read,
    input  logic [ADDR_W-1:0]  i_addr,
    output logic [LINE_W-1:0]  i_rdata,
    output logic               i_resp,
    input  logic               d_read,
    input  logic               d_write,
    input  logic [ADDR_W-1:0]  d_addr,
    input  logic [LINE_W-1:0]  d_wdata,
    output logic [LINE_W-1:0]  d_rdata,
    output logic               d_resp,
    output logic               mem_read,
    output logic               mem_write,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [BURST_W-1:0] mem_wdata,
    input  logic [BURST_W-1:0] mem_rdata,
    input  logic               mem_resp
);

    localparam int NBEATS = LINE_W / BURST_W;
    localparam int KW     = $clog2(NBEATS);

    typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, RESP} state_t;

    state_t              state_q;
    state_t              grant_d;
    logic [KW-1:0]       k_q;
    logic [KW-1:0]       kn;
    logic [LINE_W-1:0]   line_q;
    logic [ADDR_W-1:0]   addr_d;
    logic [ADDR_W-1:0]   addr_al;
    logic                d_req;
    logic                pick_i;
    logic                last_beat;
    logic [LINE_W-1:0]   i_rdata_q, d_rdata_q;
    logic                i_resp_q, d_resp_q;
    logic                mem_read_q, mem_write_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [BURST_W-1:0]  mem_wdata_q;
`ifdef ARB_RR_EN
    logic                last_d_q;
`endif

    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_resp    = i_resp_q;
    assign d_resp    = d_resp_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    assign kn        = k_q + 1'b1;
    assign last_beat = mem_resp && (k_q == KW'(NBEATS - 1));

    always_comb begin
        d_req = d_read || d_write;
`ifdef ARB_RR_EN
        // On a conflict the port served last yields
        pick_i = i_read && (!d_req || last_d_q);
`else
        pick_i = i_read && !d_req;
`endif
        grant_d = IDLE;
        addr_d  = d_addr;
        if (pick_i) begin
            grant_d = I_RD;
            addr_d  = i_addr;
        end else if (d_write) begin
            grant_d = D_WR;
        end else if (d_read) begin
            grant_d = D_RD;
        end
        addr_al = addr_d & ~(ADDR_W'(LINE_W / 8) - ADDR_W'(1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            line_q      <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_resp_q    <= 1'b0;
            d_resp_q    <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef ARB_RR_EN
            last_d_q    <= 1'b0;
`endif
        end else begin
            i_resp_q <= 1'b0;
            d_resp_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_d != IDLE) begin
                        state_q     <= grant_d;
                        mem_addr_q  <= addr_al;
                        k_q         <= '0;
                        mem_read_q  <= (grant_d != D_WR);
                        mem_write_q <= (grant_d == D_WR);
                        if (grant_d == D_WR) begin
                            line_q      <= d_wdata;
                            mem_wdata_q <= d_wdata[BURST_W-1:0];
                        end
`ifdef ARB_RR_EN
                        last_d_q <= (grant_d != I_RD);
`endif
                    end
                end
                I_RD, D_RD: begin
                    if (mem_resp) begin
                        line_q[k_q*BURST_W +: BURST_W] <= mem_rdata;
                        k_q <= kn;
                        if (last_beat) begin
                            mem_read_q <= 1'b0;
                            state_q    <= RESP;
                            // Final beat goes straight into the output line so it is valid with the pulse
                            if (state_q == I_RD) begin
                                i_rdata_q <= {mem_rdata, line_q[LINE_W-BURST_W-1:0]};
                                i_resp_q  <= 1'b1;
                            end else begin
                                d_rdata_q <= {mem_rdata, line_q[LINE_W-BURST_W-1:0]};
                                d_resp_q  <= 1'b1;
                            end
                        end
                    end
                end
                D_WR: begin
                    if (mem_resp) begin
                        k_q         <= kn;
                        mem_wdata_q <= line_q[kn*BURST_W +: BURST_W];
                        if (last_beat) begin
                            mem_write_q <= 1'b0;
                            mem_wdata_q <= '0;
                            d_resp_q    <= 1'b1;
                            state_q     <= RESP;
                        end
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst && state_q == IDLE) assert (!(d_read && d_write));
    end
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: fills, write-back, arbitration, gapped beats, stray beats, reset abort.
module tb_cache_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_read, d_read, d_write, mem_resp;
    logic [31:0]  i_addr, d_addr;
    logic [255:0] d_wdata;
    logic [63:0]  mem_rdata;
    logic [255:0] i_rdata, d_rdata;
    logic         i_resp, d_resp, mem_read, mem_write;
    logic [31:0]  mem_addr;
    logic [63:0]  mem_wdata;

    int tests = 0;
    int fails = 0;

    logic [255:0] li, ld1, li2, ld2, li3, ld3, ld4, wl;

    cache_mem_arbiter #(.LINE_W(256), .BURST_W(64), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(input string tag, input int limit);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_read || mem_write) && n < limit);
        chk({tag, "_grant"}, 256'(mem_read || mem_write), 256'(1));
    endtask

    task automatic burst(input string tag, input logic wr, input logic [255:0] line, input int gap);
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gap; g++) begin
                mem_resp = 1'b0;
                chk({tag, "_gap_strobe"}, 256'(wr ? mem_write : mem_read), 256'(1));
                @(negedge clk);
            end
            chk({tag, "_strobe"}, 256'(wr ? mem_write : mem_read), 256'(1));
            chk({tag, "_early_resp"}, 256'({i_resp, d_resp}), 256'(0));
            if (wr) chk({tag, "_wdata"}, 256'(mem_wdata), 256'(line[b*64 +: 64]));
            mem_resp  = 1'b1;
            mem_rdata = wr ? 64'h0 : line[b*64 +: 64];
            @(negedge clk);
        end
        mem_resp = 1'b0;
    endtask

    task automatic serve_read(input string tag, input logic is_i, input logic [31:0] exp_addr,
                              input logic [255:0] line, input int gap, input int limit);
        wait_grant(tag, limit);
        chk({tag, "_addr"}, 256'(mem_addr), 256'(exp_addr));
        chk({tag, "_nowrite"}, 256'(mem_write), 256'(0));
        burst(tag, 1'b0, line, gap);
        chk({tag, "_resp"}, 256'({i_resp, d_resp}), is_i ? 256'(2'b10) : 256'(2'b01));
        chk({tag, "_rdata"}, is_i ? i_rdata : d_rdata, line);
        chk({tag, "_rd_drop"}, 256'(mem_read), 256'(0));
        @(negedge clk);
        chk({tag, "_resp_end"}, 256'({i_resp, d_resp}), 256'(0));
        chk({tag, "_idle"}, 256'({mem_read, mem_write}), 256'(0));
        if (is_i) i_read = 1'b0;
        else      d_read = 1'b0;
    endtask

    initial begin
        li  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        ld1 = {64'h0D10_0000_0000_0004, 64'h0D10_0000_0000_0003,
               64'h0D10_0000_0000_0002, 64'h0D10_0000_0000_0001};
        li2 = {64'h0A20_BEEF_0000_0004, 64'h0A20_BEEF_0000_0003,
               64'h0A20_BEEF_0000_0002, 64'h0A20_BEEF_0000_0001};
        ld2 = {64'hD200_0000_CAFE_0004, 64'hD200_0000_CAFE_0003,
               64'hD200_0000_CAFE_0002, 64'hD200_0000_CAFE_0001};
        li3 = {64'h1300_0000_0000_00F4, 64'h1300_0000_0000_00F3,
               64'h1300_0000_0000_00F2, 64'h1300_0000_0000_00F1};
        ld3 = {64'hD300_5555_0000_0004, 64'hD300_5555_0000_0003,
               64'hD300_5555_0000_0002, 64'hD300_5555_0000_0001};
        ld4 = {64'hD400_0000_7777_0004, 64'hD400_0000_7777_0003,
               64'hD400_0000_7777_0002, 64'hD400_0000_7777_0001};
        for (int j = 0; j < 32; j++) wl[8*j +: 8] = 8'(j);

        rst = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_mem_read",  256'(mem_read),  256'(0));
        chk("rst_mem_write", 256'(mem_write), 256'(0));
        chk("rst_mem_addr",  256'(mem_addr),  256'(0));
        chk("rst_mem_wdata", 256'(mem_wdata), 256'(0));
        chk("rst_resp",      256'({i_resp, d_resp}), 256'(0));
        chk("rst_i_rdata",   i_rdata, 256'(0));
        chk("rst_d_rdata",   d_rdata, 256'(0));
        rst = 1'b1;
        @(negedge clk);

        // Icache fill, best-case timing
        i_read = 1'b1; i_addr = 32'h0000_1234;
        serve_read("ifill", 1'b1, 32'h0000_1220, li, 0, 1);
        @(negedge clk);
        chk("ifill_no_regrant", 256'({mem_read, mem_write, i_resp}), 256'(0));
        chk("ifill_d_rdata_untouched", d_rdata, 256'(0));

        // Simultaneous pair: dcache first, icache after one idle cycle with gapped beats
        i_read = 1'b1; i_addr = 32'h0000_0100;
        d_read = 1'b1; d_addr = 32'h0000_2000;
        serve_read("pair1_d", 1'b0, 32'h0000_2000, ld1, 0, 1);
        serve_read("pair1_i", 1'b1, 32'h0000_0100, li2, 2, 1);
        chk("pair1_d_rdata_stable", d_rdata, ld1);

        // Write-back with a gap and d_wdata changing mid-burst
        d_write = 1'b1; d_addr = 32'h8000_0040; d_wdata = wl;
        wait_grant("wb", 1);
        chk("wb_addr", 256'(mem_addr), 256'(32'h8000_0040));
        chk("wb_noread", 256'(mem_read), 256'(0));
        d_wdata = '1;
        burst("wb", 1'b1, wl, 1);
        chk("wb_resp", 256'({i_resp, d_resp}), 256'(2'b01));
        chk("wb_wr_drop", 256'(mem_write), 256'(0));
        chk("wb_d_rdata_stable", d_rdata, ld1);
        @(negedge clk);
        d_write = 1'b0;
        chk("wb_resp_end", 256'(d_resp), 256'(0));
        @(negedge clk);

        // Second simultaneous pair; dcache was served last
        i_read = 1'b1; i_addr = 32'h0000_0300;
        d_read = 1'b1; d_addr = 32'h0000_4008;
`ifdef ARB_RR_EN
        serve_read("pair2_i", 1'b1, 32'h0000_0300, li3, 0, 1);
        serve_read("pair2_d", 1'b0, 32'h0000_4000, ld2, 0, 1);
`else
        serve_read("pair2_d", 1'b0, 32'h0000_4000, ld2, 0, 1);
        serve_read("pair2_i", 1'b1, 32'h0000_0300, li3, 0, 1);
`endif
        @(negedge clk);

        // Stray beats in IDLE
        mem_resp = 1'b1; mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
        @(negedge clk);
        chk("stray_1", 256'({mem_read, mem_write, i_resp, d_resp}), 256'(0));
        @(negedge clk);
        chk("stray_2", 256'({mem_read, mem_write, i_resp, d_resp}), 256'(0));
        mem_resp = 1'b0;
        d_read = 1'b1; d_addr = 32'h0000_5010;
        serve_read("after_stray", 1'b0, 32'h0000_5000, ld3, 0, 1);
        @(negedge clk);

        // Reset during write-back beat 2
        d_write = 1'b1; d_addr = 32'h0000_6000; d_wdata = wl;
        wait_grant("rstwb", 1);
        mem_resp = 1'b1;
        repeat (2) @(negedge clk);
        mem_resp = 1'b0;
        chk("rstwb_beat2_write", 256'(mem_write), 256'(1));
        chk("rstwb_beat2_wdata", 256'(mem_wdata), 256'(wl[128 +: 64]));
        #2 rst = 1'b0;
        #1;
        chk("rstwb_async_write", 256'(mem_write), 256'(0));
        chk("rstwb_async_regs", 256'({mem_read, mem_addr, mem_wdata, i_resp, d_resp}), 256'(0));
        chk("rstwb_i_rdata", i_rdata, 256'(0));
        d_write = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        d_read = 1'b1; d_addr = 32'h0000_7000;
        serve_read("post_rst", 1'b0, 32'h0000_7000, ld4, 0, 1);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
